// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode block reader.
// State encoding, command/token bytes and error codes.
package sd_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_R1,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_TAIL,
    S_DONE
  } state_t;

  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] START_TOKEN = 8'hFE;
  localparam logic [7:0] STUFF       = 8'hFF;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_R1      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_TOKEN   = 2'd3;

endpackage

// File: rtl/sd_spi_byte.sv
// SPI mode-0 byte engine: SCK at clk/2, MSB first, 16 clk per byte.
// A start on the byte_done cycle chains the next byte with no gap.
module sd_spi_byte (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sd_miso,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       sd_ck,
  output logic       sd_mosi
);

  logic       ck_q;
  logic       mosi_q;
  logic       act_q;
  logic       done_q;
  logic [2:0] bit_q;
  logic [7:0] sh_q;
  logic [7:0] rx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ck_q   <= 1'b0;
      mosi_q <= 1'b1;
      act_q  <= 1'b0;
      done_q <= 1'b0;
      bit_q  <= 3'd0;
      sh_q   <= 8'hFF;
      rx_q   <= 8'h00;
    end else begin
      done_q <= 1'b0;
      if (act_q && !ck_q) begin
        ck_q <= 1'b1;
        rx_q <= {rx_q[6:0], sd_miso};
        if (bit_q == 3'd7) done_q <= 1'b1;
      end else if (act_q && ck_q) begin
        ck_q <= 1'b0;
        if (bit_q == 3'd7) begin
          act_q  <= 1'b0;
          mosi_q <= 1'b1;
        end else begin
          bit_q  <= bit_q + 3'd1;
          mosi_q <= sh_q[6];
          sh_q   <= {sh_q[6:0], 1'b1};
        end
      end
      if (start) begin
        act_q  <= 1'b1;
        ck_q   <= 1'b0;
        bit_q  <= 3'd0;
        mosi_q <= tx_byte[7];
        sh_q   <= tx_byte;
      end
    end
  end

  assign rx_byte   = rx_q;
  assign byte_done = done_q;
  assign sd_ck     = ck_q;
  assign sd_mosi   = mosi_q;

endmodule

// File: rtl/sd_block_read.sv
// CMD17 single-block reader: command, R1 and token polling, data
// streaming, CRC discard and a deselected trailing byte.
module sd_block_read
  import sd_pkg::*;
#(
  parameter int R1_POLL     = 8,
  parameter int TOKEN_POLL  = 4096,
  parameter int BLOCK_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic        rd_err,
  output logic [1:0]  err_code,
  output logic        sd_ck,
  output logic        sd_csn,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam int MAXA = (TOKEN_POLL > BLOCK_BYTES) ? TOKEN_POLL : BLOCK_BYTES;
  localparam int MAXN = (MAXA > R1_POLL) ? MAXA : R1_POLL;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [CW-1:0] CMD_LAST = CW'(5);
  localparam logic [CW-1:0] R1_LAST  = CW'(R1_POLL - 1);
  localparam logic [CW-1:0] TOK_LAST = CW'(TOKEN_POLL - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] CRC_LAST = CW'(1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      err_q, err_d;
  logic [31:0]     addr_q;
  logic            kick_q, kick_d;
  logic            busy_q, busy_d;
  logic            csn_q, csn_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            rerr_q, rerr_d;
  logic [7:0]      data_q, data_d;
  logic            start;
  logic [7:0]      tx;
  logic [7:0]      rx;
  logic            bdone;
  logic            accept;

  sd_spi_byte u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_byte   (tx),
    .sd_miso   (sd_miso),
    .rx_byte   (rx),
    .byte_done (bdone),
    .sd_ck     (sd_ck),
    .sd_mosi   (sd_mosi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
      addr_q  <= '0;
      kick_q  <= 1'b0;
      busy_q  <= 1'b0;
      csn_q   <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      rerr_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) addr_q <= rd_addr;
      kick_q  <= kick_d;
      busy_q  <= busy_d;
      csn_q   <= csn_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rerr_q  <= rerr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: if (rd_req && init_done) begin
        state_d = S_CMD;
        cnt_d   = '0;
        err_d   = ERR_NONE;
      end
      S_CMD: if (bdone) begin
        if (cnt_q == CMD_LAST) begin
          state_d = S_R1;
          cnt_d   = '0;
        end else cnt_d = cnt_q + ONE;
      end
      S_R1: if (bdone) begin
        if (rx == 8'h00) begin
          state_d = S_TOKEN;
          cnt_d   = '0;
        end else if (!rx[7]) begin
          state_d = S_TAIL;
          err_d   = ERR_R1;
        end else if (cnt_q == R1_LAST) begin
          state_d = S_TAIL;
          err_d   = ERR_TIMEOUT;
        end else cnt_d = cnt_q + ONE;
      end
      S_TOKEN: if (bdone) begin
        if (rx == START_TOKEN) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end else if (rx[7:4] == 4'h0) begin
          state_d = S_TAIL;
          err_d   = ERR_TOKEN;
        end else if (cnt_q == TOK_LAST) begin
          state_d = S_TAIL;
          err_d   = ERR_TIMEOUT;
        end else cnt_d = cnt_q + ONE;
      end
      S_DATA: if (bdone) begin
        if (cnt_q == DAT_LAST) begin
          state_d = S_CRC;
          cnt_d   = '0;
        end else cnt_d = cnt_q + ONE;
      end
      S_CRC: if (bdone) begin
        if (cnt_q == CRC_LAST) state_d = S_TAIL;
        else cnt_d = cnt_q + ONE;
      end
      S_TAIL: if (bdone) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign accept = (state_q == S_IDLE) && (state_d == S_CMD);

  always_comb begin
    start   = kick_q;
    tx      = STUFF;
    kick_d  = 1'b0;
    busy_d  = busy_q;
    csn_d   = csn_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rerr_d  = 1'b0;
    data_d  = data_q;
    if (accept) begin
      busy_d = 1'b1;
      csn_d  = 1'b0;
      kick_d = 1'b1;
    end
    // Deselect first, then the trailing byte starts one cycle later.
    if (state_q != S_TAIL && state_d == S_TAIL) begin
      csn_d  = 1'b1;
      kick_d = 1'b1;
    end
    if (bdone && (state_d inside {S_CMD, S_R1, S_TOKEN, S_DATA, S_CRC}))
      start = 1'b1;
    if (state_d == S_CMD) begin
      unique case (cnt_d[2:0])
        3'd0:    tx = CMD17;
        3'd1:    tx = addr_q[31:24];
        3'd2:    tx = addr_q[23:16];
        3'd3:    tx = addr_q[15:8];
        3'd4:    tx = addr_q[7:0];
        default: tx = STUFF;
      endcase
      if (accept && cnt_d[2:0] == 3'd1) tx = rd_addr[31:24];
    end
    if (state_q == S_DATA && bdone) begin
      valid_d = 1'b1;
      data_d  = rx;
    end
    if (state_q == S_TAIL && bdone) begin
      done_d = 1'b1;
      rerr_d = (err_q != ERR_NONE);
    end
    if (state_q == S_DONE) busy_d = 1'b0;
  end

  assign rd_busy  = busy_q;
  assign rd_data  = data_q;
  assign rd_valid = valid_q;
  assign rd_done  = done_q;
  assign rd_err   = rerr_q;
  assign err_code = err_q;
  assign sd_csn   = csn_q;

endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: SPI card model driven by a response script,
// with expected outcomes derived from the card-protocol rules.
module tb_sd_block_read;

  localparam int R1_POLL     = 8;
  localparam int TOKEN_POLL  = 4096;
  localparam int BLOCK_BYTES = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic        rd_busy, rd_valid, rd_done, rd_err;
  logic [7:0]  rd_data;
  logic [1:0]  err_code;
  logic        sd_ck, sd_csn, sd_mosi;
  logic        sd_miso = 1'b1;

  sd_block_read #(
    .R1_POLL(R1_POLL), .TOKEN_POLL(TOKEN_POLL), .BLOCK_BYTES(BLOCK_BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .rd_err(rd_err), .err_code(err_code), .sd_ck(sd_ck),
    .sd_csn(sd_csn), .sd_mosi(sd_mosi), .sd_miso(sd_miso)
  );

  always #10 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] script[$];
  logic [7:0] vq[$];
  logic [7:0] mosi_log[6];
  int cyc = 0, last_v = 0, bad_gap = 0, busy_cyc = 0;
  int ndone = 0, hi_rises = 0, done0 = 0;
  logic last_err = 1'b0;
  bit timed_out = 0;
  int exp_e, exp_nd, exp_busy, dstart;

  function automatic logic [7:0] sb(int k);
    if (k < script.size()) return script[k];
    return 8'hFF;
  endfunction

  // Card: first 6 bytes are the command window, then the script.
  logic ck_p = 1'b0, csn_p = 1'b1;
  logic [7:0] cur = 8'hFF, msh = 8'hFF;
  int rbits = 0, bi = 0;
  always @(sd_ck or sd_csn) begin
    if (!sd_csn && csn_p) begin
      bi = 0; rbits = 0; sd_miso = 1'b1; cur = 8'hFF;
      for (int i = 0; i < 6; i++) mosi_log[i] = 8'h00;
    end
    if (sd_ck && !ck_p) begin
      if (sd_csn) hi_rises++;
      msh = {msh[6:0], sd_mosi};
      rbits++;
      if (rbits == 8) begin
        if (bi < 6) mosi_log[bi] = msh;
        bi++;
        rbits = 0;
      end
    end else if (!sd_ck && ck_p) begin
      if (rbits == 0) cur = (bi < 6) ? 8'hFF : sb(bi - 6);
      sd_miso = cur[7 - rbits];
    end
    ck_p = sd_ck;
    csn_p = sd_csn;
  end

  always @(negedge clk) begin
    cyc++;
    if (rd_busy) busy_cyc++;
    if (rd_valid) begin
      if (vq.size() > 0 && cyc - last_v != 16) bad_gap++;
      last_v = cyc;
      vq.push_back(rd_data);
    end
    if (rd_done) begin
      ndone++;
      last_err = rd_err;
    end
  end

  task automatic model();
    int j;
    bit got;
    logic [7:0] b;
    j = 0; exp_e = 0; got = 0;
    for (int p = 0; p < R1_POLL; p++) begin
      b = sb(j); j++;
      if (b == 8'h00) begin got = 1; break; end
      if (!b[7]) begin exp_e = 1; break; end
    end
    if (!got && exp_e == 0) exp_e = 2;
    if (exp_e == 0) begin
      got = 0;
      for (int p = 0; p < TOKEN_POLL; p++) begin
        b = sb(j); j++;
        if (b == 8'hFE) begin got = 1; break; end
        if (b[7:4] == 4'h0) begin exp_e = 3; break; end
      end
      if (!got && exp_e == 0) exp_e = 2;
    end
    dstart = j;
    exp_nd = (exp_e == 0) ? BLOCK_BYTES : 0;
    if (exp_e == 0) j += BLOCK_BYTES + 2;
    exp_busy = 1 + 16 * (6 + j) + 18;
  endtask

  task automatic clear_mon();
    vq.delete();
    bad_gap = 0; busy_cyc = 0; hi_rises = 0; done0 = ndone;
  endtask

  task automatic wait_done(input int lim);
    timed_out = 0;
    for (int i = 0; i < lim && ndone == done0; i++) @(negedge clk);
    if (ndone == done0) timed_out = 1;
    @(negedge clk);
  endtask

  task automatic run_xfer(input logic [31:0] a);
    model();
    @(negedge clk);
    clear_mon();
    rd_addr = a;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    wait_done(12000);
  endtask

  function automatic int data_bad();
    int n = 0;
    for (int i = 0; i < vq.size(); i++)
      if (vq[i] !== sb(dstart + i)) n++;
    return n;
  endfunction

  task automatic test_reset();
    logic [16:0] o;
    #25;
    o = {sd_ck, sd_csn, sd_mosi, rd_busy, rd_data, rd_valid,
         rd_done, rd_err, err_code};
    total_cnt++;
    if (o !== 17'b0_1_1_0_00000000_0_0_0_00)
      $display("FAIL reset_outputs got=%b exp=%b", o, 17'b0_1_1_0_00000000_0_0_0_00);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    init_done = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_normal();
    logic [7:0] exp_cmd[6];
    int mb = 0;
    script.delete();
    repeat (2) script.push_back(8'hFF);
    script.push_back(8'h00);
    repeat (5) script.push_back(8'hFF);
    script.push_back(8'hFE);
    for (int i = 0; i < BLOCK_BYTES; i++) script.push_back(8'(i));
    script.push_back(8'hAA);
    script.push_back(8'hAA);
    run_xfer(32'h0000_1234);
    exp_cmd = '{8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'hFF};
    for (int i = 0; i < 6; i++) if (mosi_log[i] !== exp_cmd[i]) mb++;
    total_cnt++;
    if (timed_out) $display("FAIL normal_done got=none exp=rd_done");
    else pass_cnt++;
    total_cnt++;
    if (mb != 0) $display("FAIL normal_cmd got=%h %h %h %h %h %h exp=51 00 00 12 34 ff",
      mosi_log[0], mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], mosi_log[5]);
    else pass_cnt++;
    total_cnt++;
    if (vq.size() != exp_nd) $display("FAIL normal_nvalid got=%0d exp=%0d", vq.size(), exp_nd);
    else pass_cnt++;
    total_cnt++;
    if (data_bad() != 0) $display("FAIL normal_data got=%0d_bad exp=0_bad", data_bad());
    else pass_cnt++;
    total_cnt++;
    if (bad_gap != 0) $display("FAIL normal_spacing got=%0d_bad exp=0_bad", bad_gap);
    else pass_cnt++;
    total_cnt++;
    if (last_err !== 1'b0 || err_code !== 2'(exp_e))
      $display("FAIL normal_err got=%b/%0d exp=0/%0d", last_err, err_code, exp_e);
    else pass_cnt++;
    total_cnt++;
    if (hi_rises != 8) $display("FAIL normal_tail_csn got=%0d exp=8", hi_rises);
    else pass_cnt++;
    total_cnt++;
    if (busy_cyc != exp_busy) $display("FAIL normal_busy got=%0d exp=%0d", busy_cyc, exp_busy);
    else pass_cnt++;
    total_cnt++;
    if (rd_busy !== 1'b0 || sd_csn !== 1'b1)
      $display("FAIL normal_release got=%b%b exp=01", rd_busy, sd_csn);
    else pass_cnt++;
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    for (int t = 0; t < n; t++) begin
      script.delete();
      repeat ($urandom_range(0, R1_POLL - 1)) script.push_back(8'hFF);
      script.push_back(8'h00);
      repeat ($urandom_range(0, 40)) script.push_back(8'hFF);
      script.push_back(8'hFE);
      repeat (BLOCK_BYTES + 2) script.push_back(8'($urandom));
      a = $urandom;
      run_xfer(a);
      total_cnt++;
      if ({mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4]} !== a)
        $display("FAIL rand_addr got=%h%h%h%h exp=%h",
          mosi_log[1], mosi_log[2], mosi_log[3], mosi_log[4], a);
      else pass_cnt++;
      total_cnt++;
      if (vq.size() != exp_nd || data_bad() != 0)
        $display("FAIL rand_data got=%0d/%0d_bad exp=%0d/0_bad", vq.size(), data_bad(), exp_nd);
      else pass_cnt++;
      total_cnt++;
      if (busy_cyc != exp_busy || timed_out)
        $display("FAIL rand_busy got=%0d exp=%0d", busy_cyc, exp_busy);
      else pass_cnt++;
    end
  endtask

  task automatic test_err(input string nm, input int r1_ffs,
                          input logic [7:0] r1, input int use_tok,
                          input logic [7:0] tok);
    script.delete();
    repeat (r1_ffs) script.push_back(8'hFF);
    if (r1_ffs < R1_POLL) script.push_back(r1);
    if (use_tok != 0) script.push_back(tok);
    run_xfer($urandom);
    repeat (3) @(negedge clk);
    total_cnt++;
    if (timed_out || last_err !== (exp_e != 0) || err_code !== 2'(exp_e))
      $display("FAIL %s_code got=%b/%0d exp=%b/%0d", nm, last_err, err_code, exp_e != 0, exp_e);
    else pass_cnt++;
    total_cnt++;
    if (vq.size() != 0) $display("FAIL %s_nvalid got=%0d exp=0", nm, vq.size());
    else pass_cnt++;
    total_cnt++;
    if (busy_cyc != exp_busy) $display("FAIL %s_busy got=%0d exp=%0d", nm, busy_cyc, exp_busy);
    else pass_cnt++;
    total_cnt++;
    if (sd_csn !== 1'b1 || hi_rises != 8)
      $display("FAIL %s_csn got=%b/%0d exp=1/8", nm, sd_csn, hi_rises);
    else pass_cnt++;
  endtask

  task automatic test_ignore();
    script.delete();
    script.push_back(8'h04);
    model();
    @(negedge clk);
    clear_mon();
    init_done = 1'b0;
    rd_req = 1'b1;
    repeat (6) @(negedge clk);
    rd_req = 1'b0;
    total_cnt++;
    if (busy_cyc != 0 || sd_csn !== 1'b1)
      $display("FAIL ignore_no_init got=%0d/%b exp=0/1", busy_cyc, sd_csn);
    else pass_cnt++;
    init_done = 1'b1;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (20) @(negedge clk);
    rd_req = 1'b1;
    init_done = 1'b0;
    repeat (3) @(negedge clk);
    rd_req = 1'b0;
    wait_done(2000);
    init_done = 1'b1;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (timed_out || ndone - done0 != 1 || busy_cyc != exp_busy)
      $display("FAIL ignore_busy_req got=%0d/%0d exp=1/%0d", ndone - done0, busy_cyc, exp_busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int idle = 0;
    script.delete();
    script.push_back(8'h04);
    @(negedge clk);
    clear_mon();
    rd_req = 1'b1;
    for (int i = 0; i < 5 && !rd_busy; i++) @(negedge clk);
    for (int i = 0; i < 400 && rd_busy; i++) @(negedge clk);
    for (int i = 0; i < 20 && !rd_busy; i++) begin
      idle++;
      @(negedge clk);
    end
    rd_req = 1'b0;
    for (int i = 0; i < 400 && ndone - done0 < 2; i++) @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (idle != 1) $display("FAIL b2b_idle got=%0d exp=1", idle);
    else pass_cnt++;
    total_cnt++;
    if (ndone - done0 != 2 || rd_busy !== 1'b0)
      $display("FAIL b2b_count got=%0d/%b exp=2/0", ndone - done0, rd_busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [16:0] o;
    int d;
    script.delete();
    script.push_back(8'h00);
    script.push_back(8'hFE);
    for (int i = 0; i < BLOCK_BYTES + 2; i++) script.push_back(8'(i * 7));
    @(negedge clk);
    clear_mon();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 4000 && vq.size() < 99; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    d = ndone;
    #3 rst_n = 1'b0;
    #1;
    o = {sd_ck, sd_csn, sd_mosi, rd_busy, rd_data, rd_valid,
         rd_done, rd_err, err_code};
    total_cnt++;
    if (vq.size() != 99 || o !== 17'b0_1_1_0_00000000_0_0_0_00)
      $display("FAIL midrst_outputs got=%0d/%b exp=99/%b", vq.size(), o, 17'b0_1_1_0_00000000_0_0_0_00);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (ndone != d) $display("FAIL midrst_nodone got=%0d exp=%0d", ndone, d);
    else pass_cnt++;
    run_xfer(32'hCAFE_0042);
    total_cnt++;
    if (timed_out || last_err !== 1'b0 || vq.size() != exp_nd || data_bad() != 0
        || busy_cyc != exp_busy)
      $display("FAIL midrst_after got=%0d/%0d/%0d exp=%0d/0/%0d",
        vq.size(), data_bad(), busy_cyc, exp_nd, exp_busy);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_random(2);
    test_err("r1err", 0, 8'h04, 0, 8'h00);
    test_err("r1late", 3, 8'h01, 0, 8'h00);
    test_err("timeout", R1_POLL, 8'hFF, 0, 8'h00);
    test_err("tokerr", 1, 8'h00, 1, 8'h08);
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sd_block_read.md
# sd_block_read

SPI-mode single-block reader (CMD17) that sits directly downstream of the SD card initialisation stage. Once `init_done` is high, it accepts a 32-bit block address, issues CMD17, and waits for the R1 response and then the start token. It streams the 512 data bytes out one byte per strobe, then discards the CRC and releases the bus. It runs from the 50 MHz system clock and generates its own SCK at clk/2. The top level muxes its SD pins with the init stage's pins under `init_done`.

## Interface
Parameters:
- `R1_POLL`, default 8 — maximum number of bytes polled for R1 before a timeout.
- `TOKEN_POLL`, default 4096 — maximum number of bytes polled for the 0xFE start token before a timeout.
- `BLOCK_BYTES`, default 512 — number of data bytes per block.

Ports:
- `clk`  in  1  50 MHz system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `init_done`  in  1  card initialised; sampled only at request accept.
- `rd_req`  in  1  read request; level-sensitive; accepted only in IDLE.
- `rd_addr`  in  32  block address; latched on accept.
- `rd_busy`  out  1  high from the accept cycle until the cycle after `rd_done`.
- `rd_data`  out  8  received data byte; valid with `rd_valid`.
- `rd_valid`  out  1  one-cycle strobe per data byte.
- `rd_done`  out  1  one-cycle strobe when the transfer ends, with or without error.
- `rd_err`  out  1  qualifies `rd_done`; 1 means the transfer failed.
- `err_code`  out  2  1 = R1 non-zero, 2 = timeout, 3 = data error token; holds until the next accept.
- `sd_ck`  out  1  SPI clock, idle low.
- `sd_csn`  out  1  chip select, active-low.
- `sd_mosi`  out  1  SPI data out, idle high.
- `sd_miso`  in  1  SPI data in.

## Operation
- Reset values: `sd_ck`=0, `sd_csn`=1, `sd_mosi`=1, `rd_busy`=0, `rd_data`=0, `rd_valid`=0, `rd_done`=0, `rd_err`=0, `err_code`=0. The FSM resets to IDLE.
- Byte engine:
  - MSB first, mode 0.
  - `sd_ck` toggles every clk while a byte is active, so one bit is 2 clk and one byte is 16 clk.
  - `sd_mosi` updates on the clk edge where `sd_ck` goes 1→0, and the first bit is presented at byte start.
  - `sd_miso` is sampled on the clk edge where `sd_ck` goes 0→1.
  - Receive-only bytes drive `sd_mosi`=1.
- FSM states:
  - IDLE → CMD when `rd_req & init_done`. The accept latches the address, sets `rd_busy`=1 and `sd_csn`=0, and clears `err_code`.
  - CMD: send 6 bytes: 0x51, addr[31:24], [23:16], [15:8], [7:0], 0xFF. Then → R1.
  - R1: poll bytes until the received MSB is 0.
    - Byte 0x00 → TOKEN.
    - Any other byte with MSB 0 → err 1, go to TAIL.
    - `R1_POLL` bytes with MSB 1 → err 2, go to TAIL.
  - TOKEN: poll bytes.
    - 0xFE → DATA.
    - A byte with upper nibble 0000 → err 3, go to TAIL.
    - 0xFF → keep polling.
    - `TOKEN_POLL` bytes without a token → err 2, go to TAIL.
  - DATA: receive `BLOCK_BYTES` bytes; each completed byte drives `rd_data` and pulses `rd_valid`. Then → CRC.
  - CRC: receive 2 bytes and discard them. Then → TAIL.
  - TAIL: `sd_csn`=1, then clock one byte with `sd_mosi`=1 (8 SCK) → DONE.
  - DONE: `rd_done`=1 for one cycle, `rd_err` set per the error state → IDLE.
- Counters:
  - The byte counter is wide enough for `TOKEN_POLL` (13 bits at default) and is reused by every state.
  - The data counter stops exactly at `BLOCK_BYTES`-1 and never wraps.
- Boundary behaviour:
  - `rd_req` while busy is ignored and not queued.
  - `rd_req` held high is re-accepted on the cycle after DONE, giving at least one IDLE cycle.
  - `init_done` falling mid-transfer is ignored.
  - An asynchronous reset mid-transfer immediately forces all outputs to their reset values; no partial `rd_done` is issued.

## Timing
- Accept at clk edge N: `rd_busy`=1 and `sd_csn`=0 visible after N. The first `sd_ck` rise occurs at N+2.
- Command phase: 96 clk.
- `rd_valid` asserts the cycle after the 8th sample of each data byte. Data strobes are spaced exactly 16 clk apart, with no gaps inside DATA.
- `rd_done` follows TAIL by one cycle. `rd_busy` falls in the cycle after `rd_done`.
- Minimum error-free transfer, with R1 on the first poll and the token on the first poll: (6+1+1+512+2+1)×16 + 3 clk.

## Structure
- Package `sd_pkg` holds:
  - the state encoding;
  - CMD17 = 8'h51;
  - the token 8'hFE;
  - the error codes ERR_R1=1, ERR_TIMEOUT=2, ERR_TOKEN=3;
  - the stuff byte 8'hFF.
- Sub-module `sd_spi_byte` generates SCK and performs the byte shift.
  - Inputs: `start`, `tx_byte`.
  - Outputs: `rx_byte`, `byte_done` strobe, `sd_ck`, `sd_mosi`.
- `sd_block_read` contains the FSM, the counters and the output registers.

## Test plan
- Card model: R1 0x00 after 2 polls, token after 5 polls, data bytes i&0xFF, CRC 0xAAAA, address 0x00001234.
  - MOSI carries 51 00 00 12 34 FF.
  - Exactly 512 `rd_valid` strobes with bytes 00..FF repeating.
  - `rd_done` with `rd_err`=0; `sd_csn` is high during the tail byte.
- R1 = 0x04 → `rd_done` with `rd_err`=1, `err_code`=1, no `rd_valid`, `sd_csn` returns high.
- MISO stuck at 0xFF → R1 timeout after 8 polled bytes: `err_code`=2, total busy time (6+8+1)×16+3 clk.
- Error token 0x08 after R1 0x00 → `err_code`=3, no data strobes.
- `rd_req` pulsed while busy, and `init_done`=0 in IDLE → neither is accepted. `rd_req` held high → back-to-back transfers with exactly 1 IDLE cycle between `rd_busy` periods.
- `rst_n` asserted during the 100th data byte → all outputs at reset values in the same cycle. After release, a new request completes normally.
